vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port `vram` between three requesters: the display scanout reader, the CPU load/store port and a built-in block-fill engine. Each cycle the block grants at most one access, muxes its address, write enable and write data onto the VRAM port, and returns read data one cycle later. It sits between the CPU memory-mapped VRAM window, the display controller and `vram`. It is the only driver of `vram_address`, `w_enable` and `w_data`.

## Interface
Parameters:
- `ADDR_W`, 20: VRAM address width. Addresses wrap modulo 2^ADDR_W.
- `CPU_MAX_WAIT`, 4: number of consecutive display-caused CPU losses before the CPU is forced through (range 1–15).

Ports:
- `clk`  in  1  — the only clock; everything updates on posedge.
- `rst`  in  1  — reset, synchronous, active-high.
- `disp_req` in 1, `disp_addr` in ADDR_W: scanout read request.
- `disp_gnt` out 1, `disp_rvalid` out 1, `disp_rdata` out 8.
- `cpu_req` in 1, `cpu_we` in 1, `cpu_addr` in ADDR_W, `cpu_wdata` in 8: CPU access.
- `cpu_gnt` out 1, `cpu_rvalid` out 1, `cpu_rdata` out 8.
- `fill_start` in 1, `fill_base` in ADDR_W, `fill_len` in ADDR_W+1, `fill_value` in 8: fill command.
- `fill_busy` out 1, `fill_done` out 1.
- `vram_address` out ADDR_W, `w_enable` out 1, `w_data` out 8: connect to the VRAM port.
- `r_data` in 8: VRAM read data.

## Operation
- Handshake: a requester holds `req` and its fields stable until it sees `gnt`. `gnt` is combinational and lasts exactly one cycle per access. A requester may present a new request in the cycle after a grant.
- Priority per cycle:
  - A forced CPU grant wins first.
  - Otherwise the display wins.
  - Then the CPU, provided no fill is in progress.
  - Then the fill engine.
  - If nothing is granted, `w_enable=0` and `vram_address` holds its last value.
- Starvation counter (4 bit):
  - Increments each cycle in which `cpu_req` is high and is denied only because the display was granted.
  - When it equals `CPU_MAX_WAIT`, the CPU is granted over the display in the next eligible cycle and the counter clears.
  - Also clears on any CPU grant and whenever `cpu_req` is low.
  - The counter never forces past a fill: the CPU does not participate while `fill_busy` is high.
- Fill FSM states:
  - IDLE: on `fill_start` with `fill_len`≠0, latch base, length and value, then go to RUN. `fill_start` with `fill_len`=0 pulses `fill_done` next cycle and stays in IDLE.
  - RUN: on each fill grant, write `fill_value` at the current pointer, increment the pointer (wrapping at 2^ADDR_W) and decrement the remaining count. When the count reaches 0 after a grant, go to DONE.
  - DONE: `fill_done`=1 for one cycle, then IDLE.
  - `fill_busy`=1 in RUN and DONE. `fill_start` is ignored while busy.
- Reads: a read grant (display, or CPU with `cpu_we`=0) captures `r_data` at the posedge ending the grant cycle into that requester's rdata register. The corresponding `rvalid` goes high for one cycle.
- CPU writes produce no `rvalid`.
- Display and CPU rdata registers are independent. Each holds its value until its next read.

## Timing
- Grant in cycle N. VRAM write commits at the posedge ending cycle N. Read data and `rvalid` are valid throughout cycle N+1 (one-cycle read latency). The VRAM reads on negedge, so `r_data` is stable by that posedge.
- Back-to-back grants to the same or different requesters are allowed every cycle: full throughput.
- While `rst` is high:
  - All `gnt`=0, `w_enable`=0.
  - Next state: `vram_address`=0, `disp_rvalid`=`cpu_rvalid`=0, both rdata=0, FSM=IDLE, `fill_busy`=`fill_done`=0, starvation counter=0.
- Reset during RUN aborts the fill with no `fill_done`. Writes already issued are kept.
- A fill of length 2^ADDR_W covers the whole memory and returns the pointer to base.

## Structure
- Package `vram_pkg`: `ADDR_W` default, `vram_req_e` {REQ_NONE, REQ_DISP, REQ_CPU, REQ_FILL}, `fill_state_e` {FILL_IDLE, FILL_RUN, FILL_DONE}.
- Sub-module `vram_fill_engine`: contains the FSM, pointer and count. It exposes `req`/`gnt`/`addr`/`data` like the other requesters plus `busy`/`done`.
- Top level: priority logic, starvation counter, port mux and read-return registers.

## Test plan
- Display reads 0x00010 with the memory preloaded (`mem[i]=i`) → `disp_gnt` in cycle N, `disp_rvalid`=1 and `disp_rdata`=0x10 in N+1.
- CPU writes 0xA5 to 0x00200, then reads 0x00200 in the next cycle → second access has `cpu_rvalid` with 0xA5 one cycle later, and no `rvalid` for the write.
- `disp_req` held high continuously while `cpu_req` is high, `CPU_MAX_WAIT`=4 → the CPU is granted exactly after 4 display grants, repeating every 5 cycles.
- Fill base 0xFFFFE, len 4, value 0x3C, no display traffic → writes at 0xFFFFE, 0xFFFFF, 0x00000, 0x00001. `fill_done` occurs one cycle after the last write. A CPU request during the fill is granted only after `fill_busy` falls.
- Fill len 8 with the display requesting on alternate cycles → the fill takes 8 free slots, no display grant is lost, and the `fill_done` pulse is single-cycle.
- `rst` asserted mid-fill (after 3 writes) → `fill_busy` is 0 next cycle, no `fill_done`, addresses 3 onward are untouched, and all outputs are at their reset values.

Source files
------------

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and defaults for the VRAM arbiter
package vram_pkg;

    // Default VRAM address width (1 MiB of byte-wide video memory)
    localparam int ADDR_W_DEFAULT = 20;

    // Default number of display-caused CPU losses before the CPU is forced through
    localparam int CPU_MAX_WAIT_DEFAULT = 4;

    // Which requester owns the VRAM port in the current cycle
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_DISP = 2'd1,
        REQ_CPU  = 2'd2,
        REQ_FILL = 2'd3
    } vram_req_e;

    // Block-fill engine states
    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/vram_fill_engine.sv
// rtl/vram_fill_engine.sv - block-fill requester: writes one value over a wrapping address range
module vram_fill_engine
    import vram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [7:0]        value_i,
    input  logic              gnt_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        data_o,
    output logic              busy_o,
    output logic              done_o
);

    fill_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [7:0]         value_q, value_d;
    // A zero-length command never leaves IDLE but still reports completion
    logic               zero_done_q, zero_done_d;

    // State and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FILL_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            value_q     <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Next-state logic: leave RUN once the grant for the final byte arrives
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL_IDLE: if (start_i && (len_i != '0)) state_d = FILL_RUN;
            FILL_RUN:  if (gnt_i && (cnt_q == (ADDR_W+1)'(1))) state_d = FILL_DONE;
            FILL_DONE: state_d = FILL_IDLE;
            default:   state_d = FILL_IDLE;
        endcase
    end

    // Pointer/count/value update: latch on accepted start, advance on each grant
    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        zero_done_d = 1'b0;
        if (state_q == FILL_IDLE && start_i) begin
            if (len_i != '0) begin
                ptr_d   = base_i;
                cnt_d   = len_i;
                value_d = value_i;
            end else begin
                zero_done_d = 1'b1;
            end
        end
        if (state_q == FILL_RUN && gnt_i) begin
            ptr_d = ptr_q + ADDR_W'(1);
            cnt_d = cnt_q - (ADDR_W+1)'(1);
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        req_o  = (state_q == FILL_RUN);
        busy_o = (state_q != FILL_IDLE);
        done_o = (state_q == FILL_DONE) || zero_done_q;
    end

    assign addr_o = ptr_q;
    assign data_o = value_q;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter for display, CPU and fill engine
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [7:0]        disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [7:0]        fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] vram_address,
    output logic              w_enable,
    output logic [7:0]        w_data,
    input  logic [7:0]        r_data
);

    logic              fill_req;
    logic              fill_gnt;
    logic [ADDR_W-1:0] fill_addr;
    logic [7:0]        fill_data;

    vram_req_e         sel;
    logic              cpu_ok;
    logic              cpu_forced;

    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic              disp_rvalid_q, cpu_rvalid_q;
    logic [7:0]        disp_rdata_q, cpu_rdata_q;

    vram_fill_engine #(
        .ADDR_W (ADDR_W)
    ) u_fill (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (fill_start),
        .base_i  (fill_base),
        .len_i   (fill_len),
        .value_i (fill_value),
        .gnt_i   (fill_gnt),
        .req_o   (fill_req),
        .addr_o  (fill_addr),
        .data_o  (fill_data),
        .busy_o  (fill_busy),
        .done_o  (fill_done)
    );

    // The CPU sits out entirely while a fill owns the memory, so the
    // starvation override can never cut into a fill
    assign cpu_ok     = cpu_req && !fill_busy;
    assign cpu_forced = cpu_ok && (starve_q == 4'(CPU_MAX_WAIT));

    // Fixed-priority pick: forced CPU, display, CPU, fill; nothing in reset
    always_comb begin
        sel = REQ_NONE;
        if (!rst) begin
            if (cpu_forced)    sel = REQ_CPU;
            else if (disp_req) sel = REQ_DISP;
            else if (cpu_ok)   sel = REQ_CPU;
            else if (fill_req) sel = REQ_FILL;
        end
    end

    assign disp_gnt = (sel == REQ_DISP);
    assign cpu_gnt  = (sel == REQ_CPU);
    assign fill_gnt = (sel == REQ_FILL);

    // Port mux; the address parks on its last driven value when idle
    always_comb begin
        vram_address = addr_hold_q;
        w_enable     = 1'b0;
        w_data       = 8'h00;
        case (sel)
            REQ_DISP: vram_address = disp_addr;
            REQ_CPU: begin
                vram_address = cpu_addr;
                w_enable     = cpu_we;
                w_data       = cpu_wdata;
            end
            REQ_FILL: begin
                vram_address = fill_addr;
                w_enable     = 1'b1;
                w_data       = fill_data;
            end
            default: ;
        endcase
    end

    // Starvation count: only losses to the display while eligible accumulate
    always_comb begin
        starve_d = starve_q;
        if (!cpu_req || cpu_gnt)     starve_d = 4'd0;
        else if (disp_gnt && cpu_ok) starve_d = starve_q + 4'd1;
    end

    // Starvation counter and parked address
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= 4'd0;
            addr_hold_q <= '0;
        end else begin
            starve_q    <= starve_d;
            addr_hold_q <= vram_address;
        end
    end

    // Read return: capture r_data at the edge closing a read grant
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= 8'h00;
            cpu_rvalid_q  <= 1'b0;
            cpu_rdata_q   <= 8'h00;
        end else begin
            disp_rvalid_q <= disp_gnt;
            cpu_rvalid_q  <= cpu_gnt && !cpu_we;
            if (disp_gnt)            disp_rdata_q <= r_data;
            if (cpu_gnt && !cpu_we)  cpu_rdata_q  <= r_data;
        end
    end

    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

    localparam int AW   = 20;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt, disp_rvalid;
    logic [7:0]    disp_rdata;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [7:0]    cpu_rdata;
    logic          fill_start;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_len;
    logic [7:0]    fill_value;
    logic          fill_busy, fill_done;
    logic [AW-1:0] vram_address;
    logic          w_enable;
    logic [7:0]    w_data;
    logic [7:0]    r_data;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .CPU_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .vram_address(vram_address), .w_enable(w_enable), .w_data(w_data),
        .r_data(r_data)
    );

    // VRAM: preloaded mem[i] = i, reads on negedge, writes on posedge
    logic [7:0] vmem [0:(1<<AW)-1];
    always @(negedge clk) r_data <= vmem[vram_address];
    always @(posedge clk) if (w_enable) vmem[vram_address] = w_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned  ref_mem [int];
    int            fill_q [$];
    logic [7:0]    fill_val_m;
    int            losses_m;
    bit            run_done_m, zero_done_m, busy_m, cpu_ok_m;
    logic [AW-1:0] last_addr_m, exp_addr_m;
    bit            drv_m, crv_m;
    logic [7:0]    drd_m, crd_m;
    int            win;   // 0 none, 1 display, 2 cpu, 3 fill

    function automatic logic [7:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'(a);
    endfunction

    task automatic eval_cycle(input bit do_chk);
        bit wen;
        logic [7:0] wd;
        #3;
        busy_m   = (fill_q.size() != 0) || run_done_m;
        cpu_ok_m = cpu_req && !busy_m;
        if (rst)                               win = 0;
        else if (cpu_ok_m && losses_m >= MAXW) win = 2;
        else if (disp_req)                     win = 1;
        else if (cpu_ok_m)                     win = 2;
        else if (fill_q.size() != 0)           win = 3;
        else                                   win = 0;
        case (win)
            1:       exp_addr_m = disp_addr;
            2:       exp_addr_m = cpu_addr;
            3:       exp_addr_m = AW'(fill_q[0]);
            default: exp_addr_m = last_addr_m;
        endcase
        wen = (win == 2 && cpu_we) || win == 3;
        wd  = (win == 3) ? fill_val_m : cpu_wdata;
        if (do_chk) begin
            chk("m_disp_gnt", disp_gnt, win == 1);
            chk("m_cpu_gnt", cpu_gnt, win == 2);
            chk("m_w_enable", w_enable, wen);
            chk("m_vram_address", vram_address, exp_addr_m);
            if (wen) chk("m_w_data", w_data, wd);
            chk("m_disp_rvalid", disp_rvalid, drv_m);
            chk("m_disp_rdata", disp_rdata, drd_m);
            chk("m_cpu_rvalid", cpu_rvalid, crv_m);
            chk("m_cpu_rdata", cpu_rdata, crd_m);
            chk("m_fill_busy", fill_busy, busy_m);
            chk("m_fill_done", fill_done, run_done_m || zero_done_m);
        end
    endtask

    task automatic advance();
        bit rd_n, zd_n;
        if (rst) begin
            losses_m = 0; fill_q.delete(); run_done_m = 0; zero_done_m = 0;
            last_addr_m = '0; drv_m = 0; crv_m = 0; drd_m = 8'h00; crd_m = 8'h00;
        end else begin
            drv_m = (win == 1);
            if (win == 1) drd_m = ref_rd(int'(disp_addr));
            crv_m = (win == 2 && !cpu_we);
            if (crv_m) crd_m = ref_rd(int'(cpu_addr));
            if (win == 2 && cpu_we) ref_mem[int'(cpu_addr)] = cpu_wdata;
            if (win == 3) begin
                ref_mem[fill_q[0]] = fill_val_m;
                void'(fill_q.pop_front());
            end
            if (!cpu_req || win == 2)      losses_m = 0;
            else if (win == 1 && cpu_ok_m) losses_m++;
            rd_n = (win == 3) && (fill_q.size() == 0);
            zd_n = fill_start && !busy_m && (fill_len == 0);
            if (fill_start && !busy_m && fill_len != 0) begin
                fill_val_m = fill_value;
                for (int k = 0; k < int'(fill_len); k++)
                    fill_q.push_back((int'(fill_base) + k) % (1 << AW));
            end
            run_done_m  = rd_n;
            zero_done_m = zd_n;
            if (win != 0) last_addr_m = exp_addr_m;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req = 0; disp_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = 8'h00;
        fill_start = 0; fill_base = '0; fill_len = '0; fill_value = 8'h00;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit dr; logic [AW-1:0] da;
        bit cr; bit cwe; logic [AW-1:0] ca; logic [7:0] cd;
        bit dg; bit cg; bit wen; logic [AW-1:0] addr;
        bit drv; logic [7:0] drd; bit crv; logic [7:0] crd;
    } vec_t;

    function automatic vec_t mk(bit dr, int da, bit cr, bit cwe, int ca, int cd,
                                bit dg, bit cg, bit wen, int addr,
                                bit drv, int drd, bit crv, int crd);
        vec_t v;
        v.dr = dr; v.da = AW'(da); v.cr = cr; v.cwe = cwe; v.ca = AW'(ca); v.cd = 8'(cd);
        v.dg = dg; v.cg = cg; v.wen = wen; v.addr = AW'(addr);
        v.drv = drv; v.drd = 8'(drd); v.crv = crv; v.crd = 8'(crd);
        return v;
    endfunction

    initial begin
        vec_t vt [16];
        logic [AW-1:0] wrap_exp [4];
        int writes, dreq, dgn, dones, done_k;
        bit dpend, cpend;

        for (int i = 0; i < (1 << AW); i++) vmem[i] = 8'(i);
        losses_m = 0; run_done_m = 0; zero_done_m = 0; last_addr_m = '0;
        drv_m = 0; crv_m = 0; drd_m = 0; crd_m = 0; fill_val_m = 0; win = 0;

        //             dr da     cr we ca      cd    dg cg wen addr     drv drd   crv crd
        vt[0]  = mk(1, 'h10,  0, 0, 0,      0,    1, 0, 0, 'h10,    0, 0,    0, 0);
        vt[1]  = mk(0, 0,     1, 1, 'h200,  'hA5, 0, 1, 1, 'h200,   1, 'h10, 0, 0);
        vt[2]  = mk(0, 0,     1, 0, 'h200,  0,    0, 1, 0, 'h200,   0, 'h10, 0, 0);
        vt[3]  = mk(0, 0,     0, 0, 0,      0,    0, 0, 0, 'h200,   0, 'h10, 1, 'hA5);
        vt[4]  = mk(0, 0,     0, 0, 0,      0,    0, 0, 0, 'h200,   0, 'h10, 0, 'hA5);
        vt[5]  = mk(1, 'h20,  1, 0, 'h30,   0,    1, 0, 0, 'h20,    0, 'h10, 0, 'hA5);
        vt[6]  = mk(1, 'h20,  1, 0, 'h30,   0,    1, 0, 0, 'h20,    1, 'h20, 0, 'hA5);
        vt[7]  = mk(1, 'h20,  1, 0, 'h30,   0,    1, 0, 0, 'h20,    1, 'h20, 0, 'hA5);
        vt[8]  = mk(1, 'h20,  1, 0, 'h30,   0,    1, 0, 0, 'h20,    1, 'h20, 0, 'hA5);
        vt[9]  = mk(1, 'h20,  1, 0, 'h30,   0,    0, 1, 0, 'h30,    1, 'h20, 0, 'hA5);
        vt[10] = mk(1, 'h20,  1, 0, 'h30,   0,    1, 0, 0, 'h20,    0, 'h20, 1, 'h30);
        vt[11] = mk(1, 'h20,  1, 0, 'h30,   0,    1, 0, 0, 'h20,    1, 'h20, 0, 'h30);
        vt[12] = mk(1, 'h20,  1, 0, 'h30,   0,    1, 0, 0, 'h20,    1, 'h20, 0, 'h30);
        vt[13] = mk(1, 'h20,  1, 0, 'h30,   0,    1, 0, 0, 'h20,    1, 'h20, 0, 'h30);
        vt[14] = mk(1, 'h20,  1, 0, 'h30,   0,    0, 1, 0, 'h30,    1, 'h20, 0, 'h30);
        vt[15] = mk(0, 0,     0, 0, 0,      0,    0, 0, 0, 'h30,    0, 'h20, 1, 'h30);

        wrap_exp[0] = 20'hFFFFE; wrap_exp[1] = 20'hFFFFF;
        wrap_exp[2] = 20'h00000; wrap_exp[3] = 20'h00001;

        // reset: two cycles, second one checked
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        eval_cycle(0);
        advance();
        eval_cycle(1);
        chk("rst_disp_gnt", disp_gnt, 0);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_w_enable", w_enable, 0);
        chk("rst_vram_address", vram_address, 0);
        chk("rst_fill_busy", fill_busy, 0);
        advance();
        rst = 0;

        // table: display read, CPU write/read-back, starvation override
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            disp_req = vt[i].dr; disp_addr = vt[i].da;
            cpu_req = vt[i].cr; cpu_we = vt[i].cwe; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
            eval_cycle(1);
            chk($sformatf("t%0d_disp_gnt", i), disp_gnt, vt[i].dg);
            chk($sformatf("t%0d_cpu_gnt", i), cpu_gnt, vt[i].cg);
            chk($sformatf("t%0d_w_enable", i), w_enable, vt[i].wen);
            chk($sformatf("t%0d_vram_address", i), vram_address, vt[i].addr);
            chk($sformatf("t%0d_disp_rvalid", i), disp_rvalid, vt[i].drv);
            chk($sformatf("t%0d_disp_rdata", i), disp_rdata, vt[i].drd);
            chk($sformatf("t%0d_cpu_rvalid", i), cpu_rvalid, vt[i].crv);
            chk($sformatf("t%0d_cpu_rdata", i), cpu_rdata, vt[i].crd);
            advance();
        end

        // fill wrapping at the top of memory, CPU blocked until busy drops
        idle_inputs();
        fill_start = 1; fill_base = 20'hFFFFE; fill_len = 21'd4; fill_value = 8'h3C;
        eval_cycle(1);
        chk("wrap_busy_pre", fill_busy, 0);
        advance();
        fill_start = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00005;
        for (int k = 0; k < 5; k++) begin
            eval_cycle(1);
            chk($sformatf("wrap%0d_wen", k), w_enable, k < 4);
            if (k < 4) chk($sformatf("wrap%0d_addr", k), vram_address, wrap_exp[k]);
            chk($sformatf("wrap%0d_cpu_gnt", k), cpu_gnt, 0);
            chk($sformatf("wrap%0d_busy", k), fill_busy, 1);
            chk($sformatf("wrap%0d_done", k), fill_done, k == 4);
            advance();
        end
        eval_cycle(1);
        chk("wrap_cpu_after", cpu_gnt, 1);
        chk("wrap_busy_after", fill_busy, 0);
        chk("wrap_done_after", fill_done, 0);
        advance();
        cpu_req = 0;
        for (int k = 0; k < 4; k++) chk($sformatf("wrap_mem%0d", k), vmem[wrap_exp[k]], 8'h3C);
        chk("wrap_mem_untouched", vmem[2], 8'h02);

        // fill of 8 interleaved with display requests on alternate cycles
        idle_inputs();
        fill_start = 1; fill_base = 20'h00100; fill_len = 21'd8; fill_value = 8'h77;
        eval_cycle(1);
        advance();
        writes = 0; dreq = 0; dgn = 0; dones = 0; done_k = -1;
        for (int k = 1; k <= 20; k++) begin
            idle_inputs();
            disp_req = (k % 2 == 1); disp_addr = AW'(32'h300 + k);
            eval_cycle(1);
            if (w_enable) writes++;
            if (disp_req) dreq++;
            if (disp_gnt) dgn++;
            if (fill_done) begin dones++; done_k = k; end
            advance();
        end
        chk("alt_fill_writes", writes, 8);
        chk("alt_disp_grants", dgn, dreq);
        chk("alt_done_cycles", dones, 1);
        chk("alt_done_at", done_k, 17);

        // reset in the middle of a fill
        idle_inputs();
        fill_start = 1; fill_base = 20'h00400; fill_len = 21'd8; fill_value = 8'hEE;
        eval_cycle(1);
        advance();
        fill_start = 0;
        for (int k = 0; k < 3; k++) begin
            eval_cycle(1);
            chk($sformatf("mid%0d_wen", k), w_enable, 1);
            advance();
        end
        rst = 1;
        eval_cycle(1);
        chk("mid_rst_wen", w_enable, 0);
        advance();
        rst = 0;
        eval_cycle(1);
        chk("mid_busy", fill_busy, 0);
        chk("mid_done", fill_done, 0);
        chk("mid_addr", vram_address, 0);
        chk("mid_disp_rvalid", disp_rvalid, 0);
        chk("mid_cpu_rvalid", cpu_rvalid, 0);
        chk("mid_disp_rdata", disp_rdata, 0);
        chk("mid_cpu_rdata", cpu_rdata, 0);
        advance();
        for (int k = 0; k < 8; k++) begin
            eval_cycle(1);
            chk("mid_post_done", fill_done, 0);
            chk("mid_post_wen", w_enable, 0);
            advance();
        end
        for (int k = 0; k < 8; k++)
            chk($sformatf("mid_mem%0d", k), vmem[20'h400 + k], (k < 3) ? 8'hEE : 8'(k));

        // randomized traffic against the model
        dpend = 0; cpend = 0;
        idle_inputs();
        for (int c = 0; c < 4000; c++) begin
            if (!dpend && $urandom_range(3) != 0) begin
                dpend = 1;
                disp_addr = AW'($urandom_range(0, 255));
            end
            if (!cpend && $urandom_range(1) == 0) begin
                cpend = 1;
                cpu_we = $urandom_range(1) == 1;
                cpu_addr = ($urandom_range(7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 255));
                cpu_wdata = 8'($urandom);
            end
            disp_req = dpend;
            cpu_req = cpend;
            fill_start = ($urandom_range(24) == 0);
            fill_base = ($urandom_range(3) == 0) ? AW'(32'hFFFF8 + $urandom_range(0, 7))
                                                 : AW'($urandom_range(0, 255));
            fill_len = (AW+1)'($urandom_range(0, 12));
            fill_value = 8'($urandom);
            rst = ($urandom_range(599) == 0);
            eval_cycle(1);
            if (win == 1) dpend = 0;
            if (win == 2) cpend = 0;
            advance();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
